// File: rtl/jtag_tap_bscan_if.sv
// Pad/core boundary and TAP serial pins for jtag_tap_bscan.
// master: the side that drives TMS/TDI, pads and core outputs (board/bench).
// slave : the TAP controller itself.
interface jtag_tap_bscan_if #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned N_OUT = 8
);
  logic              TMS;
  logic              TDI;
  logic              TDO;
  logic [N_IN-1:0]   pin_in;
  logic [N_IN-1:0]   core_in;
  logic [N_OUT-1:0]  core_out;
  logic [N_OUT-1:0]  pin_out;
  logic              extest;

  modport master (
    output TMS, TDI, pin_in, core_out,
    input  TDO, core_in, pin_out, extest
  );

  modport slave (
    input  TMS, TDI, pin_in, core_out,
    output TDO, core_in, pin_out, extest
  );
endinterface

// File: rtl/jtag_tap_bscan.sv
// IEEE 1149.1-style TAP controller with boundary-scan register.
// Instructions: EXTEST (all zeros), SAMPLE/PRELOAD (1), IDCODE (2),
// BYPASS (all ones and any undecoded opcode).
// Optional macro TAP_USERCODE_EN adds the USERCODE parameter and opcode 3.
module jtag_tap_bscan #(
  parameter int unsigned IR_WIDTH = 4,
  parameter logic [31:0] IDCODE   = 32'hF00ED093,
`ifdef TAP_USERCODE_EN
  parameter logic [31:0] USERCODE = 32'h0000_0000,
`endif
  parameter int unsigned N_IN     = 8,
  parameter int unsigned N_OUT    = 8
) (
  input  logic            TCK,
  input  logic            TRSTn,
  jtag_tap_bscan_if.slave bus
);

  localparam int unsigned BSR_W = N_IN + N_OUT;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
`ifdef TAP_USERCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(3);
`endif

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {DR_BSR, DR_ID, DR_USER, DR_BYP} dr_sel_e;

  tap_state_e          r_state;
  tap_state_e          w_next;
  dr_sel_e             w_sel;
  logic                w_tdo;
  logic                w_extest;

  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [31:0]         r_id;     // shared by IDCODE and USERCODE
  logic                r_byp;
  logic [BSR_W-1:0]    r_bsr;
  logic [BSR_W-1:0]    r_upd;

  // TAP state register
  always_ff @(posedge TCK) begin
    if (!TRSTn) r_state <= ST_TLR;
    else        r_state <= w_next;
  end

  // Standard TMS-driven state transitions
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_TLR:      w_next = bus.TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      w_next = bus.TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   w_next = bus.TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   w_next = bus.TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: w_next = bus.TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: w_next = bus.TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: w_next = bus.TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: w_next = bus.TMS ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   w_next = bus.TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   w_next = bus.TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   w_next = bus.TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: w_next = bus.TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: w_next = bus.TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: w_next = bus.TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: w_next = bus.TMS ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   w_next = bus.TMS ? ST_SEL_DR   : ST_RTI;
      default:     w_next = ST_TLR;
    endcase
  end

  // Instruction decode: data register selection, EXTEST flag and TDO mux
  always_comb begin
    w_sel    = DR_BYP;
    w_tdo    = 1'b0;
    w_extest = (r_ir == OP_EXTEST);
    if (r_ir == OP_EXTEST || r_ir == OP_SAMPLE) w_sel = DR_BSR;
    else if (r_ir == OP_IDCODE)                 w_sel = DR_ID;
`ifdef TAP_USERCODE_EN
    else if (r_ir == OP_USER)                   w_sel = DR_USER;
`endif
    if (r_state == ST_SHIFT_IR) begin
      w_tdo = r_ir_sr[0];
    end else if (r_state == ST_SHIFT_DR) begin
      case (w_sel)
        DR_BSR:         w_tdo = r_bsr[0];
        DR_ID, DR_USER: w_tdo = r_id[0];
        default:        w_tdo = r_byp;
      endcase
    end
  end

  // Instruction register: capture/shift, and active IR reload.
  // IDCODE is loaded on the edge that enters TLR so the soft reset
  // deasserts EXTEST in the same cycle as the hard one.
  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      r_ir    <= OP_IDCODE;
      r_ir_sr <= '0;
    end else begin
      if (r_state == ST_CAP_IR)        r_ir_sr <= IR_WIDTH'(1);
      else if (r_state == ST_SHIFT_IR) r_ir_sr <= {bus.TDI, r_ir_sr[IR_WIDTH-1:1]};
      if (w_next == ST_TLR)            r_ir <= OP_IDCODE;
      else if (r_state == ST_UPD_IR)   r_ir <= r_ir_sr;
    end
  end

  // Data registers: capture, shift and boundary update latches
  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      r_id  <= '0;
      r_byp <= 1'b0;
      r_bsr <= '0;
      r_upd <= '0;
    end else begin
      case (r_state)
        ST_CAP_DR: begin
          case (w_sel)
            DR_BSR:  r_bsr <= {bus.core_out, bus.pin_in};
            DR_ID:   r_id  <= IDCODE;
`ifdef TAP_USERCODE_EN
            DR_USER: r_id  <= USERCODE;
`endif
            default: r_byp <= 1'b0;
          endcase
        end
        ST_SHIFT_DR: begin
          case (w_sel)
            DR_BSR:         r_bsr <= {bus.TDI, r_bsr[BSR_W-1:1]};
            DR_ID, DR_USER: r_id  <= {bus.TDI, r_id[31:1]};
            default:        r_byp <= bus.TDI;
          endcase
        end
        ST_UPD_DR: begin
          if (w_sel == DR_BSR) r_upd <= r_bsr;
        end
        default: ;
      endcase
    end
  end

  assign bus.TDO     = w_tdo;
  assign bus.extest  = w_extest;
  assign bus.core_in = w_extest ? r_upd[N_IN-1:0]     : bus.pin_in;
  assign bus.pin_out = w_extest ? r_upd[BSR_W-1:N_IN] : bus.core_out;

endmodule

// File: doc/jtag_tap_bscan.md
Name: jtag_tap_bscan

Overview:
Parametrised IEEE 1149.1-style TAP controller with an integrated boundary-scan register (BSR). It sits between a core and its pads, and generalises the fixed MAC wrapper TAP to any pin count, IR width and IDCODE. It adds SAMPLE/PRELOAD and EXTEST so that core I/O can be observed and driven through scan. Single TCK domain; no other clocks.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE, 32'hF00ED093, value captured into the 32-bit ID register
N_IN, 8, number of input boundary cells (pad to core)
N_OUT, 8, number of output boundary cells (core to pad)

Ports:
TCK  in  1  scan clock; all state updates on posedge
TRSTn  in  1  synchronous active-low reset, sampled on posedge TCK
TMS  in  1  TAP mode select
TDI  in  1  serial data in
TDO  out  1  serial data out
pin_in  in  N_IN  values from input pads
core_in  out  N_IN  values driven into core inputs
core_out  in  N_OUT  values from core outputs
pin_out  out  N_OUT  values driven to output pads
extest  out  1  high while the active instruction is EXTEST

Behaviour:
- Reset: TRSTn=0 at posedge -> state Test-Logic-Reset (TLR), IR=IDCODE opcode, BSR shift and update latches all 0. TDO=0 and extest=0.
- FSM: all 16 standard TAP states, standard TMS transitions, evaluated on posedge TCK. Five TMS=1 posedges from any state reach TLR, which also forces IR=IDCODE.
- Opcodes: EXTEST={IR_WIDTH{0}}; SAMPLE/PRELOAD=1; IDCODE=2; BYPASS=all ones. Any other opcode selects BYPASS.
- Capture-IR: IR shift register loads ...0001 (bit0=1, upper bits 0).
- Shift-IR: shift right, TDI enters MSB. Update-IR: active IR <= IR shift register.
- DR selection by active IR:
  - IDCODE: 32-bit shift register. Capture loads IDCODE; Shift shifts right with TDI into bit31.
  - BYPASS: 1-bit register. Capture loads 0.
  - EXTEST and SAMPLE/PRELOAD: BSR of N_IN+N_OUT cells. Bits [N_IN-1:0] are input cells; bit0 is nearest TDO. Capture loads {core_out, pin_in}. Shift shifts right, TDI into the MSB. Update-DR copies the shift register into the update latches.
- TDO is combinational: LSB of the selected shift register in Shift-DR/Shift-IR, otherwise 0. A bench sampling TDO at posedge therefore sees bit0 of the captured value first.
- Muxing:
  - extest=0: core_in=pin_in and pin_out=core_out (transparent).
  - extest=1: core_in=update latch input cells and pin_out=update latch output cells.
- Capture, Shift and Update states do not occur together; Pause/Exit states hold the shift registers unchanged.
- TRSTn low mid-shift: TLR at that edge, shift data is discarded, update latches clear, outputs go transparent on the same cycle.
- Widths: no arithmetic. Counters are not needed; all sizing comes from the parameters.

Optional Feature:
Macro TAP_USERCODE_EN.
- Defined: adds parameter USERCODE (default 32'h0000_0000) and opcode USERCODE=3, a 32-bit DR captured with USERCODE and shifted like IDCODE.
- Undefined: opcode 3 decodes as BYPASS.

Test Plan:
- IDCODE read: TRSTn pulse, TMS 1,0,1,0,0 to reach Shift-DR, shift 32'h0000007F -> TDO yields 32'hF00ED093. A second 32 shifts of 0 -> 32'h0000007F.
- IR capture and BYPASS: shift IR with TDI 4'b1111 -> TDO reads 4'b0001; Update-IR. Shift DR 8'hA5 -> TDO yields 0 then the A5 bits delayed by one cycle.
- SAMPLE: IR=1, pin_in=8'h3C, core_out=8'hC3, Capture-DR, shift 16 -> TDO returns 16'hC33C. pin_out stays equal to core_out throughout.
- EXTEST: PRELOAD 16'h5A96 via SAMPLE, then load IR=0 -> extest=1, pin_out=8'h5A, core_in=8'h96 immediately after Update-IR.
- Soft reset: from Shift-DR, hold TMS=1 for 5 edges -> TLR, extest=0, IR reads back as IDCODE.
- Sync reset mid-operation: TRSTn=0 for one posedge during EXTEST Shift-DR -> next cycle TLR, core_in=pin_in, TDO=0.
